cordic_seq_ctrl: RTL and testbench

Parametrised control path for the iterative CORDIC engine. It replaces the fixed two-state controller with the following:
- a programmable iteration count with an internal iteration counter;
- run-time selection of rotation or vectoring mode;
- a valid/ready result handshake;
- a synchronous abort.

It drives the existing CORDIC datapath through register-load, iterate and direction strobes, and supplies the shift amount and arctangent-LUT index for each iteration.

---
 rtl/cordic_seq_ctrl_if.sv | 33 +++
 rtl/cordic_seq_ctrl.sv | 143 ++++++++++++++
 tb/tb_cordic_seq_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/cordic_seq_ctrl_if.sv
// Handshake and datapath-strobe bundle between the CORDIC sequencer and its surroundings.
// Signal suffixes are seen from the controller side: _i is driven into it, _o is driven by it.
interface cordic_seq_ctrl_if #(
  parameter int N_ITER = 16
);
  localparam int IDX_W = (N_ITER > 1) ? $clog2(N_ITER) : 1;

  logic             start_i;
  logic             mode_i;
  logic             z_sign_i;
  logic             y_sign_i;
  logic             abort_i;
  logic             out_ready_i;
  logic             in_ready_o;
  logic             load_regs_o;
  logic             iter_o;
  logic             add_o;
  logic             sub_o;
  logic [IDX_W-1:0] idx_o;
  logic             scale_o;
  logic             busy_o;
  logic             out_valid_o;

  modport master (
    output start_i, mode_i, z_sign_i, y_sign_i, abort_i, out_ready_i,
    input  in_ready_o, load_regs_o, iter_o, add_o, sub_o, idx_o, scale_o, busy_o, out_valid_o
  );

  modport slave (
    input  start_i, mode_i, z_sign_i, y_sign_i, abort_i, out_ready_i,
    output in_ready_o, load_regs_o, iter_o, add_o, sub_o, idx_o, scale_o, busy_o, out_valid_o
  );
endinterface

// File: rtl/cordic_seq_ctrl.sv
// Iterative CORDIC control path: programmable iteration count, rotation/vectoring, valid/ready result, abort.
// Define CORDIC_GAIN_COMP_EN to add a one-cycle gain-compensation (scale) state after the last iteration.
module cordic_seq_ctrl #(
  parameter int BIT_WIDTH = 16,
  parameter int N_ITER    = 16
) (
  input logic               clk,
  input logic               reset,
  cordic_seq_ctrl_if.slave  bus
);

  localparam int IDX_W = (N_ITER > 1) ? $clog2(N_ITER) : 1;
  // Shifting past the datapath width is meaningless, so an out-of-range count is clamped.
  localparam int LAST_IDX = ((N_ITER > BIT_WIDTH) ? BIT_WIDTH : ((N_ITER < 1) ? 1 : N_ITER)) - 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_HOLD    = 2'd2
`ifdef CORDIC_GAIN_COMP_EN
    ,S_SCALE  = 2'd3
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             mode_q, mode_d;
  logic             inReady_q, inReady_d;
  logic             iterOn_q, iterOn_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic             lastIter;
  logic             dirAdd;
`ifdef CORDIC_GAIN_COMP_EN
  logic             scale_q, scale_d;
`endif

  assign lastIter = (idx_q == IDX_W'(LAST_IDX));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mode_d  = mode_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          state_d = S_COMPUTE;
          idx_d   = '0;
          mode_d  = bus.mode_i;
        end
      end
      S_COMPUTE: begin
        if (bus.abort_i) begin
          state_d = S_IDLE;
          idx_d   = '0;
        end else if (lastIter) begin
`ifdef CORDIC_GAIN_COMP_EN
          state_d = S_SCALE;
`else
          state_d = S_HOLD;
`endif
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
`ifdef CORDIC_GAIN_COMP_EN
      S_SCALE: begin
        if (bus.abort_i) begin
          state_d = S_IDLE;
          idx_d   = '0;
        end else begin
          state_d = S_HOLD;
        end
      end
`endif
      S_HOLD: begin
        if (bus.abort_i || bus.out_ready_i) begin
          state_d = S_IDLE;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase

    // Moore flags are precomputed from the next state so the outputs come straight from flops.
    inReady_d = (state_d == S_IDLE);
    iterOn_d  = (state_d == S_COMPUTE);
    valid_d   = (state_d == S_HOLD);
`ifdef CORDIC_GAIN_COMP_EN
    scale_d   = (state_d == S_SCALE);
    busy_d    = (state_d == S_COMPUTE) || (state_d == S_SCALE);
`else
    busy_d    = (state_d == S_COMPUTE);
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      mode_q    <= 1'b0;
      inReady_q <= 1'b1;
      iterOn_q  <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
`ifdef CORDIC_GAIN_COMP_EN
      scale_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      mode_q    <= mode_d;
      inReady_q <= inReady_d;
      iterOn_q  <= iterOn_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
`ifdef CORDIC_GAIN_COMP_EN
      scale_q   <= scale_d;
`endif
    end
  end

  // Rotation drives z toward zero, vectoring drives y toward zero; the sign inputs are live.
  assign dirAdd = mode_q ? bus.y_sign_i : ~bus.z_sign_i;

  assign bus.in_ready_o  = inReady_q;
  assign bus.load_regs_o = inReady_q & bus.start_i & ~reset;
  assign bus.iter_o      = iterOn_q & ~bus.abort_i;
  assign bus.add_o       = iterOn_q & ~bus.abort_i & dirAdd;
  assign bus.sub_o       = iterOn_q & ~bus.abort_i & ~dirAdd;
  assign bus.idx_o       = idx_q;
  assign bus.busy_o      = busy_q;
  assign bus.out_valid_o = valid_q & ~bus.abort_i;
`ifdef CORDIC_GAIN_COMP_EN
  assign bus.scale_o     = scale_q & ~bus.abort_i;
`else
  assign bus.scale_o     = 1'b0;
`endif

endmodule

// File: tb/tb_cordic_seq_ctrl.sv
// Directed table-driven bench for cordic_seq_ctrl with N_ITER=16.
// Flag vector order: {in_ready, load_regs, iter, add, sub, scale, busy, out_valid}.
module tb_cordic_seq_ctrl;

  localparam int N_ITER = 16;
  localparam int IDX_W  = (N_ITER > 1) ? $clog2(N_ITER) : 1;

  localparam logic [7:0] F_IDLE  = 8'b1000_0000;
  localparam logic [7:0] F_LOAD  = 8'b1100_0000;
  localparam logic [7:0] F_ADD   = 8'b0011_0010;
  localparam logic [7:0] F_SUB   = 8'b0010_1010;
  localparam logic [7:0] F_ABORT = 8'b0000_0010;
  localparam logic [7:0] F_SCALE = 8'b0000_0110;
  localparam logic [7:0] F_HOLD  = 8'b0000_0001;
  localparam logic [7:0] F_NONE  = 8'b0000_0000;

  typedef struct {
    logic             start;
    logic             mode;
    logic             zSign;
    logic             ySign;
    logic             abort;
    logic             outReady;
    logic [7:0]       expFlags;
    logic             chkIdx;
    logic [IDX_W-1:0] expIdx;
    string            name;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad = 0;
  vec_t vecs[$];

  cordic_seq_ctrl_if #(.N_ITER(N_ITER)) bus ();

  cordic_seq_ctrl #(.BIT_WIDTH(16), .N_ITER(N_ITER)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic addVec(input logic st, input logic md, input logic zs, input logic ys,
                        input logic ab, input logic ordy, input logic [7:0] flags,
                        input logic chk, input int ix, input string nm);
    vec_t v;
    v.start    = st;
    v.mode     = md;
    v.zSign    = zs;
    v.ySign    = ys;
    v.abort    = ab;
    v.outReady = ordy;
    v.expFlags = flags;
    v.chkIdx   = chk;
    v.expIdx   = IDX_W'(ix);
    v.name     = nm;
    vecs.push_back(v);
  endtask

  task automatic addScaleIfEnabled(input string nm);
`ifdef CORDIC_GAIN_COMP_EN
    addVec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, F_SCALE, 1'b1, N_ITER - 1, nm);
`else
    if (nm.len() < 0) addVec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, F_SCALE, 1'b1, 0, nm);
`endif
  endtask

  task automatic applyStimulus(input logic st, input logic md, input logic zs, input logic ys,
                               input logic ab, input logic ordy);
    @(negedge clk);
    bus.start_i     = st;
    bus.mode_i      = md;
    bus.z_sign_i    = zs;
    bus.y_sign_i    = ys;
    bus.abort_i     = ab;
    bus.out_ready_i = ordy;
    #1;
  endtask

  task automatic checkOutput(input string nm, input logic [7:0] expFlags,
                             input logic chkIdx, input logic [IDX_W-1:0] expIdx);
    logic [7:0] got;
    got = {bus.in_ready_o, bus.load_regs_o, bus.iter_o, bus.add_o, bus.sub_o,
           bus.scale_o, bus.busy_o, bus.out_valid_o};
    total++;
    if (got !== expFlags) begin
      bad++;
      $display("[TB] FAIL %s flags got=%b expected=%b at %0t", nm, got, expFlags, $time);
    end
    if (chkIdx) begin
      total++;
      if (bus.idx_o !== expIdx) begin
        bad++;
        $display("[TB] FAIL %s idx got=%0d expected=%0d at %0t", nm, bus.idx_o, expIdx, $time);
      end
    end
  endtask

  task automatic runVecs();
    for (int k = 0; k < vecs.size(); k++) begin
      applyStimulus(vecs[k].start, vecs[k].mode, vecs[k].zSign, vecs[k].ySign,
                    vecs[k].abort, vecs[k].outReady);
      checkOutput(vecs[k].name, vecs[k].expFlags, vecs[k].chkIdx, vecs[k].expIdx);
    end
  endtask

  initial begin
    bus.start_i     = 1'b0;
    bus.mode_i      = 1'b0;
    bus.z_sign_i    = 1'b0;
    bus.y_sign_i    = 1'b0;
    bus.abort_i     = 1'b0;
    bus.out_ready_i = 1'b0;
    #2 reset = 1'b1;

    // Reset state, including start held high while reset is asserted.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("resetState", F_IDLE, 1'b1, '0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("resetLoadGated", F_IDLE, 1'b1, '0);
    @(negedge clk);
    bus.start_i = 1'b0;
    reset = 1'b0;

    // Idle, abort ignored while idle.
    for (int i = 0; i < 5; i++) addVec(0, 0, 0, 0, 0, 0, F_IDLE, 1, 0, "idle");
    addVec(0, 0, 0, 0, 1, 0, F_IDLE, 1, 0, "idleAbortIgnored");

    // Rotation, z_sign=0 so every step adds; start during compute ignored.
    addVec(1, 0, 0, 0, 0, 1, F_LOAD, 0, 0, "rotStart");
    for (int i = 0; i < N_ITER; i++) addVec(i == 3, 1, 0, 0, 0, 1, F_ADD, 1, i, "rotIter");
    addScaleIfEnabled("rotScale");
    addVec(0, 0, 0, 0, 0, 1, F_HOLD, 1, N_ITER - 1, "rotHold");
    addVec(0, 0, 0, 0, 0, 0, F_IDLE, 0, 0, "rotBackIdle");

    // Vectoring, y_sign alternating from 1, mode input toggling, z_sign opposite of y.
    addVec(1, 1, 0, 0, 0, 0, F_LOAD, 0, 0, "vecStart");
    for (int i = 0; i < N_ITER; i++) begin
      logic ys;
      ys = (i % 2 == 0);
      addVec(0, i[0], ~ys, ys, 0, 0, ys ? F_ADD : F_SUB, 1, i, "vecIter");
    end
    addScaleIfEnabled("vecScale");
    for (int k = 0; k < 7; k++) addVec(k % 2 == 0, 0, 0, 0, 0, 0, F_HOLD, 1, N_ITER - 1, "vecHoldStall");
    addVec(0, 0, 0, 0, 0, 1, F_HOLD, 1, N_ITER - 1, "vecHoldRelease");
    addVec(0, 0, 0, 0, 0, 0, F_IDLE, 0, 0, "vecBackIdle");

    // Rotation with z_sign=1 (subtract), aborted at idx 5.
    addVec(1, 0, 1, 0, 0, 0, F_LOAD, 0, 0, "abStart");
    for (int i = 0; i < 5; i++) addVec(0, 0, 1, 0, 0, 0, F_SUB, 1, i, "abIter");
    addVec(0, 0, 1, 0, 1, 0, F_ABORT, 1, 5, "abAbort");
    for (int k = 0; k < 20; k++) addVec(0, 0, 1, 0, 0, 1, F_IDLE, 0, 0, "abIdleNoResult");

    // start+abort together in idle is accepted; out_ready+abort in hold drops the result.
    addVec(1, 0, 0, 0, 1, 0, F_LOAD, 0, 0, "startWithAbort");
    for (int i = 0; i < N_ITER; i++) addVec(0, 0, 0, 0, 0, 0, F_ADD, 1, i, "saIter");
    addScaleIfEnabled("saScale");
    addVec(0, 0, 0, 0, 1, 1, F_NONE, 1, N_ITER - 1, "holdAbortReady");
    addVec(0, 0, 0, 0, 0, 0, F_IDLE, 0, 0, "saBackIdle");
    addVec(0, 0, 0, 0, 0, 0, F_IDLE, 0, 0, "saIdle2");

    runVecs();

    // Asynchronous reset in the middle of a compute cycle.
    vecs.delete();
    addVec(1, 0, 0, 0, 0, 0, F_LOAD, 0, 0, "arStart");
    for (int i = 0; i < 8; i++) addVec(0, 0, 0, 0, 0, 0, F_ADD, 1, i, "arIter");
    runVecs();
    @(posedge clk);
    #2 reset = 1'b1;
    #1 checkOutput("asyncResetMid", F_IDLE, 1'b1, '0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("asyncResetLoadGated", F_IDLE, 1'b1, '0);
    @(negedge clk);
    bus.start_i = 1'b0;
    reset = 1'b0;

    // Fresh full operation after reset release runs all iterations from idx 0.
    vecs.delete();
    addVec(1, 0, 0, 0, 0, 1, F_LOAD, 0, 0, "postStart");
    for (int i = 0; i < N_ITER; i++) addVec(0, 0, 0, 0, 0, 1, F_ADD, 1, i, "postIter");
    addScaleIfEnabled("postScale");
    addVec(0, 0, 0, 0, 0, 1, F_HOLD, 1, N_ITER - 1, "postHold");
    addVec(0, 0, 0, 0, 0, 0, F_IDLE, 0, 0, "postBackIdle");
    runVecs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
